// File: rtl/uart_inport.sv
// uart_inport: 8N1 serial receiver feeding the CPU input port.
// Ports:
//   clk, reset        - datapath clock, async active-high reset
//   rx                - async serial line, idle high
//   ack               - pulse, clears word_valid/frame_err/overrun
//   inport_ext_input  - last completed little-endian 32-bit word
//   word_valid        - sticky, word completed since last ack
//   frame_err         - sticky, stop bit sampled low
//   overrun           - sticky, word completed while word_valid set
module uart_inport #(
   parameter int CLKS_PER_BIT = 217,
   parameter int REG_SIZE     = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx,
   input  logic                ack,
   output logic [REG_SIZE-1:0] inport_ext_input,
   output logic                word_valid,
   output logic                frame_err,
   output logic                overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic                sync1_q, sync1_d;
   logic                rxs_q, rxs_d;
   logic                rxs_dly_q, rxs_dly_d;
   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [1:0]          byte_cnt_q, byte_cnt_d;
   logic [REG_SIZE-1:0] shreg_q, shreg_d;
   logic [REG_SIZE-1:0] word_q, word_d;
   logic                word_valid_q, word_valid_d;
   logic                frame_err_q, frame_err_d;
   logic                overrun_q, overrun_d;

   logic                byte_ok;
   logic                stop_err;
   logic                word_done;

   always_comb begin
      sync1_d    = rx;
      rxs_d      = sync1_q;
      rxs_dly_d  = rxs_q;
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      bit_idx_d  = bit_idx_q;
      byte_cnt_d = byte_cnt_q;
      shreg_d    = shreg_q;
      byte_ok    = 1'b0;
      stop_err   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            // falling edge only; a line stuck low cannot retrigger
            if (rxs_dly_q && !rxs_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               state_d   = rxs_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               shreg_d[{byte_cnt_q, bit_idx_q}] = rxs_q;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (rxs_q) begin
                  byte_ok    = 1'b1;
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end else begin
                  stop_err   = 1'b1;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign word_done = byte_ok && (byte_cnt_q == 2'd3);

   // same-cycle sets take priority over ack clears
   always_comb begin
      word_d       = word_done ? shreg_q : word_q;
      word_valid_d = word_valid_q;
      frame_err_d  = frame_err_q;
      overrun_d    = overrun_q;
      if (ack) begin
         word_valid_d = 1'b0;
         frame_err_d  = 1'b0;
         overrun_d    = 1'b0;
      end
      if (word_done) begin
         word_valid_d = 1'b1;
         if (word_valid_q && !ack) begin
            overrun_d = 1'b1;
         end
      end
      if (stop_err) begin
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q      <= 1'b1;
         rxs_q        <= 1'b1;
         rxs_dly_q    <= 1'b1;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= 3'd0;
         byte_cnt_q   <= 2'd0;
         shreg_q      <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         rxs_q        <= rxs_d;
         rxs_dly_q    <= rxs_dly_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         byte_cnt_q   <= byte_cnt_d;
         shreg_q      <= shreg_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign inport_ext_input = word_q;
   assign word_valid       = word_valid_q;
   assign frame_err        = frame_err_q;
   assign overrun          = overrun_q;

endmodule

// File: tb/tb_uart_inport.sv
// tb_uart_inport: scoreboard bench for uart_inport at 8 clks/bit.
// Words are queued when sent and popped when the DUT publishes one.
module tb_uart_inport;

   localparam int C = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic        ack = 1'b0;
   logic [31:0] inport;
   logic        word_valid;
   logic        frame_err;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb[$];
   logic [31:0] in_prev = 32'd0;
   logic        wv_prev = 1'b0;

   uart_inport #(
      .CLKS_PER_BIT(C),
      .REG_SIZE(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx(rx),
      .ack(ack),
      .inport_ext_input(inport),
      .word_valid(word_valid),
      .frame_err(frame_err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // a new word shows as a valid rise or a changed value
   always @(negedge clk) begin
      if (!reset && ((word_valid && !wv_prev) || inport != in_prev)) begin
         if (sb.size() == 0)
            check("sb_underflow", 32'(sb.size()), 32'd1);
         else
            check("word", inport, sb.pop_front());
      end
      in_prev = inport;
      wv_prev = word_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // with C=8 the stop sample lands on the 10C-th edge of the frame
   task automatic send_byte(input logic [7:0] b, input logic stop,
                            input logic ack_end);
      rx = 1'b0;
      tick(C);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(C);
      end
      rx = stop;
      tick(C - 1);
      ack = ack_end;
      tick(1);
      ack = 1'b0;
      rx = 1'b1;
      tick(C);
   endtask

   task automatic send_word(input logic [31:0] w, input logic ack_end);
      sb.push_back(w);
      for (int i = 0; i < 4; i++)
         send_byte(w[8*i +: 8], 1'b1, ack_end && (i == 3));
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
   endtask

   task automatic flags(input string tag, input logic wv,
                        input logic fe, input logic ov);
      check({tag, "_wv"}, 32'(word_valid), 32'(wv));
      check({tag, "_fe"}, 32'(frame_err), 32'(fe));
      check({tag, "_ov"}, 32'(overrun), 32'(ov));
   endtask

   initial begin
      tick(3);
      check("rst_word", inport, 32'd0);
      flags("rst", 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      tick(2);

      send_word(32'hDEADBEEF, 1'b0);
      check("t1_word", inport, 32'hDEADBEEF);
      flags("t1", 1'b1, 1'b0, 1'b0);
      pulse_ack();
      flags("t1_ack", 1'b0, 1'b0, 1'b0);

      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(3 * C);
      flags("t2_false", 1'b0, 1'b0, 1'b0);
      send_word(32'h01020304, 1'b0);
      flags("t2", 1'b1, 1'b0, 1'b0);
      pulse_ack();

      send_byte(8'h55, 1'b0, 1'b0);
      flags("t3_ferr", 1'b0, 1'b1, 1'b0);
      send_word(32'h44332211, 1'b0);
      check("t3_word", inport, 32'h44332211);
      flags("t3", 1'b1, 1'b1, 1'b0);
      pulse_ack();
      flags("t3_ack", 1'b0, 1'b0, 1'b0);
      check("t3_keep", inport, 32'h44332211);

      send_word(32'h11111111, 1'b0);
      send_word(32'h22222222, 1'b0);
      check("t4_word", inport, 32'h22222222);
      flags("t4_ovr", 1'b1, 1'b0, 1'b1);
      send_word(32'h33333333, 1'b1);
      flags("t4_ackc", 1'b1, 1'b0, 1'b0);

      send_byte(8'hAA, 1'b1, 1'b0);
      send_byte(8'hBB, 1'b1, 1'b0);
      rx = 1'b0;
      tick(C);
      rx = 1'b1;
      tick(2 * C);
      reset = 1'b1;
      tick(1);
      check("t5_word", inport, 32'd0);
      flags("t5_rst", 1'b0, 1'b0, 1'b0);
      tick(2);
      reset = 1'b0;
      tick(2 * C);
      send_word(32'hCAFEF00D, 1'b0);
      flags("t5", 1'b1, 1'b0, 1'b0);
      pulse_ack();

      reset = 1'b1;
      rx = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(30 * C);
      flags("t6_low", 1'b0, 1'b1, 1'b0);
      pulse_ack();
      tick(12 * C);
      flags("t6_hold", 1'b0, 1'b0, 1'b0);
      rx = 1'b1;
      tick(2 * C);
      send_word(32'h89ABCDEF, 1'b0);
      flags("t6", 1'b1, 1'b0, 1'b0);

      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
